// File: rtl/rx_symbol_aligner.sv
// Bit-serial receive front end: shifts in one bit per CLK_5G edge, hunts for the K28.5 comma
// at any phase, realigns the 10-bit word boundary to it and tracks symbol lock.
module rx_symbol_aligner #(
  parameter int              DATA_WIDTH = 10,
  parameter logic [9:0]      COMMA_NEG  = 10'h17C,
  parameter logic [9:0]      COMMA_POS  = 10'h283,
  parameter int              LOCK_CNT   = 4,
  parameter int              UNLOCK_CNT = 4
) (
  input  logic                  CLK_5G,
  input  logic                  Rst,
  input  logic                  Serial_In,
  input  logic                  Align_En,
  output logic [DATA_WIDTH-1:0] Collected_Data,
  output logic                  Word_Valid,
  output logic                  Comma_Seen,
  output logic                  Symbol_Lock,
  output logic                  Realign
);

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_CONFIRM = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  localparam logic [3:0] BIT_LAST = 4'(DATA_WIDTH - 1);
  localparam logic [2:0] LOCK_C   = 3'(LOCK_CNT);
  localparam logic [2:0] UNLOCK_C = 3'(UNLOCK_CNT);

  state_t                r_state, w_state_nxt;
  logic [DATA_WIDTH-1:0] r_sr;
  logic [3:0]            r_bit_cnt;
  logic [2:0]            r_good, r_bad, w_good_nxt, w_bad_nxt, w_good_inc, w_bad_inc;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_word_valid, r_comma_seen, r_lock, r_realign;

  logic [DATA_WIDTH-1:0] w_window;
  logic                  w_match, w_boundary, w_realign_now, w_emit;

  // The newest bit lands in the MSB so the first-received bit ends up in bit0.
  assign w_window      = {Serial_In, r_sr[DATA_WIDTH-1:1]};
  assign w_match       = (w_window == COMMA_NEG) || (w_window == COMMA_POS);
  assign w_boundary    = (r_bit_cnt == BIT_LAST);
  assign w_realign_now = w_match && !w_boundary && Align_En && (r_state != ST_LOCKED);
  assign w_emit        = w_boundary || w_realign_now;

  assign w_good_inc = (r_good == 3'h7) ? r_good : r_good + 3'd1;
  assign w_bad_inc  = (r_bad  == 3'h7) ? r_bad  : r_bad  + 3'd1;

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned
  // and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_good_nxt  = r_good;
    w_bad_nxt   = r_bad;
    if (w_match) begin
      case (r_state)
        ST_SEARCH: begin
          if (Align_En) begin
            w_good_nxt  = 3'd1;
            w_state_nxt = ST_CONFIRM;
          end
        end
        ST_CONFIRM: begin
          if (!Align_En) begin
            w_good_nxt  = 3'd0;
            w_state_nxt = ST_SEARCH;
          end else if (w_boundary) begin
            w_good_nxt = w_good_inc;
            if (w_good_inc >= LOCK_C) begin
              w_bad_nxt   = 3'd0;
              w_state_nxt = ST_LOCKED;
            end
          end else begin
            w_good_nxt = 3'd1;
          end
        end
        ST_LOCKED: begin
          if (w_boundary) begin
            w_bad_nxt = 3'd0;
          end else begin
            w_bad_nxt = w_bad_inc;
            if (w_bad_inc >= UNLOCK_C) begin
              w_good_nxt  = 3'd0;
              w_state_nxt = ST_SEARCH;
            end
          end
        end
        default: w_state_nxt = ST_SEARCH;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge CLK_5G or posedge Rst) begin
    if (Rst) begin
      r_sr         <= '0;
      r_bit_cnt    <= '0;
      r_state      <= ST_SEARCH;
      r_good       <= '0;
      r_bad        <= '0;
      r_data       <= '0;
      r_word_valid <= 1'b0;
      r_comma_seen <= 1'b0;
      r_lock       <= 1'b0;
      r_realign    <= 1'b0;
    end else begin
      r_sr      <= w_window;
      r_state   <= w_state_nxt;
      r_good    <= w_good_nxt;
      r_bad     <= w_bad_nxt;
      r_lock    <= (w_state_nxt == ST_LOCKED);
      r_realign <= w_realign_now;
      if (w_emit) begin
        r_data       <= w_window;
        r_word_valid <= 1'b1;
        r_comma_seen <= w_match;
        r_bit_cnt    <= '0;
      end else begin
        r_word_valid <= 1'b0;
        r_comma_seen <= 1'b0;
        r_bit_cnt    <= r_bit_cnt + 4'd1;
      end
    end
  end

  assign Collected_Data = r_data;
  assign Word_Valid     = r_word_valid;
  assign Comma_Seen     = r_comma_seen;
  assign Symbol_Lock    = r_lock;
  assign Realign        = r_realign;

endmodule
